// File: rtl/lcd_frame_engine.sv
// HD44780 character-LCD controller: power-up init, custom glyph upload and
// ROWS x COLS frame streaming, one byte every three FSM ticks.
module lcd_frame_engine #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned STEP_HZ    = 800,
  parameter int unsigned COLS       = 16,
  parameter int unsigned ROWS       = 2,
  parameter int unsigned CG_GLYPHS  = 8,
  parameter int unsigned CONTINUOUS = 1,
  localparam int unsigned AW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic          Clk,
  input  logic          rst,
  input  logic          refresh_req,
  output logic          busy,
  output logic          frame_done,
  output logic [AW-1:0] char_addr,
  input  logic [7:0]    char_data,
  output logic [5:0]    cg_addr,
  input  logic [7:0]    cg_data,
  inout  logic [7:0]    LCD_DATA,
  output logic          LCD_EN,
  output logic          LCD_RW,
  output logic          LCD_RS
);

  localparam int unsigned DIV = CLK_HZ / STEP_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [5:0]  CG_LAST = 6'(CG_GLYPHS * 8 - 1);

  typedef enum logic [3:0] {
    S_FUNC, S_DISP, S_CLEAR, S_CLRWAIT, S_ENTRY,
    S_CGHOME, S_CGDATA, S_IDLE, S_ROWCMD, S_CHAR
  } state_t;

  typedef enum logic [1:0] {P_SETUP, P_DROP, P_HOLD} phase_t;

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [CW-1:0]   cnt_q;
  logic            tick;
  logic            wait_q, wait_d;
  logic            pending_q, pending_d;
  logic            row_q, row_d;
  logic [CLW-1:0]  col_q, col_d;
  logic [AW-1:0]   char_addr_d;
  logic [5:0]      cg_addr_d;
  logic [7:0]      data_q, data_d;
  logic            en_d, rs_d, frame_done_d;
  logic            frame_start;
  logic [7:0]      byte_sel;
  logic            rs_sel;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= tick ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    byte_sel = 8'h00;
    rs_sel   = 1'b0;
    case (state_q)
      S_FUNC:   byte_sel = (ROWS == 2) ? 8'h38 : 8'h30;
      S_DISP:   byte_sel = 8'h0C;
      S_CLEAR:  byte_sel = 8'h01;
      S_ENTRY:  byte_sel = 8'h06;
      S_CGHOME: byte_sel = 8'h40;
      S_CGDATA: begin byte_sel = cg_data; rs_sel = 1'b1; end
      S_ROWCMD: byte_sel = row_q ? 8'hC0 : 8'h80;
      S_CHAR:   begin byte_sel = char_data; rs_sel = 1'b1; end
      default:  byte_sel = 8'h00;
    endcase
  end

  // Frame start clears pending, absorbing any request on that same cycle.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    wait_d       = wait_q;
    row_d        = row_q;
    col_d        = col_q;
    char_addr_d  = char_addr;
    cg_addr_d    = cg_addr;
    data_d       = data_q;
    en_d         = LCD_EN;
    rs_d         = LCD_RS;
    frame_done_d = 1'b0;
    frame_start  = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE:    frame_start = (CONTINUOUS != 0) || pending_q;
        S_CLRWAIT: begin
          if (wait_q) state_d = S_ENTRY;
          else        wait_d  = 1'b1;
        end
        default: begin
          case (phase_q)
            P_SETUP: begin
              en_d    = 1'b1;
              data_d  = byte_sel;
              rs_d    = rs_sel;
              phase_d = P_DROP;
            end
            P_DROP: begin
              en_d    = 1'b0;
              phase_d = P_HOLD;
            end
            default: begin
              phase_d = P_SETUP;
              case (state_q)
                S_FUNC:  state_d = S_DISP;
                S_DISP:  state_d = S_CLEAR;
                S_CLEAR: begin state_d = S_CLRWAIT; wait_d = 1'b0; end
                S_ENTRY: state_d = (CG_GLYPHS > 0) ? S_CGHOME : S_IDLE;
                S_CGHOME: begin state_d = S_CGDATA; cg_addr_d = '0; end
                S_CGDATA: begin
                  if (cg_addr == CG_LAST) state_d = S_IDLE;
                  else                    cg_addr_d = cg_addr + 1'b1;
                end
                S_ROWCMD: begin state_d = S_CHAR; col_d = '0; end
                S_CHAR: begin
                  if (col_q != CLW'(COLS - 1)) begin
                    col_d       = col_q + 1'b1;
                    char_addr_d = char_addr + 1'b1;
                  end else if (row_q != 1'(ROWS - 1)) begin
                    row_d       = 1'b1;
                    char_addr_d = char_addr + 1'b1;
                    state_d     = S_ROWCMD;
                  end else begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                    frame_start  = (CONTINUOUS != 0) || pending_q;
                  end
                end
                default: state_d = S_IDLE;
              endcase
            end
          endcase
        end
      endcase
    end
    if (frame_start) begin
      state_d     = S_ROWCMD;
      phase_d     = P_SETUP;
      row_d       = 1'b0;
      col_d       = '0;
      char_addr_d = '0;
    end
    pending_d = frame_start ? 1'b0 : (pending_q | refresh_req);
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FUNC;
      phase_q    <= P_SETUP;
      wait_q     <= 1'b0;
      pending_q  <= 1'b0;
      row_q      <= 1'b0;
      col_q      <= '0;
      char_addr  <= '0;
      cg_addr    <= '0;
      data_q     <= '0;
      LCD_EN     <= 1'b0;
      LCD_RS     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      wait_q     <= wait_d;
      pending_q  <= pending_d;
      row_q      <= row_d;
      col_q      <= col_d;
      char_addr  <= char_addr_d;
      cg_addr    <= cg_addr_d;
      data_q     <= data_d;
      LCD_EN     <= en_d;
      LCD_RS     <= rs_d;
      frame_done <= frame_done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign LCD_RW   = 1'b0;
  assign LCD_DATA = LCD_RW ? 'z : data_q;

endmodule
